// File: rtl/aes_key_expand_ctrl.sv
// -----------------------------------------------------------------------------
// aes_key_expand_ctrl
//   Sequencer for AES-128 key expansion. Latches a cipher key on start, then
//   emits round keys 0..NUM_ROUNDS in order over a valid/ready stream. Between
//   two keys it spends one CALC cycle, in which it drives the round-constant
//   lookup (rcon_keyid -> rcon_byte) and the external SubWord S-box
//   (sub_in -> sub_out) and folds the results into the next round key.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        load key_in and begin (ignored while busy)
//   abort        synchronous abandon, back to IDLE next cycle
//   key_in       cipher key, w0 in [127:96] .. w3 in [31:0]
//   rcon_keyid   round-constant lookup index (0 outside a schedule)
//   rcon_byte    round-constant byte returned combinationally for rcon_keyid
//   sub_in       RotWord(w3) sent to the external S-box
//   sub_out      SubWord(sub_in), combinational
//   rk_valid     round key valid
//   rk_ready     consumer accepts rk_data
//   rk_data      current round key
//   rk_round     round index of rk_data, 0..NUM_ROUNDS
//   busy         high from start accept until the final handshake
//   done         one-cycle pulse after the last round key is accepted
// -----------------------------------------------------------------------------
module aes_key_expand_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] key_in,
    output logic [3:0]   rcon_keyid,
    input  logic [7:0]   rcon_byte,
    output logic [31:0]  sub_in,
    input  logic [31:0]  sub_out,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        OUT,
        CALC
    } state_t;

    state_t       state;
    logic [127:0] key_reg;

    // Word view of the current round key; w0 is the most significant word.
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] nw0, nw1, nw2, nw3;

    assign w0 = key_reg[127:96];
    assign w1 = key_reg[95:64];
    assign w2 = key_reg[63:32];
    assign w3 = key_reg[31:0];

    // RotWord: rotate w3 left by one byte before the S-box.
    assign sub_in = {w3[23:0], w3[31:24]};

    // Round constant lands in the top byte of the substituted word.
    assign t   = sub_out ^ {rcon_byte, 24'h0};
    assign nw0 = w0 ^ t;
    assign nw1 = w1 ^ nw0;
    assign nw2 = w2 ^ nw1;
    assign nw3 = w3 ^ nw2;

    assign rk_data = key_reg;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge regardless of the
    // order the statements are written in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            key_reg    <= '0;
            rk_round   <= '0;
            rcon_keyid <= '0;
            rk_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Abort outranks start and any same-cycle handshake.
                state      <= IDLE;
                rk_valid   <= 1'b0;
                busy       <= 1'b0;
                rcon_keyid <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            key_reg    <= key_in;
                            rk_round   <= '0;
                            rcon_keyid <= '0;
                            busy       <= 1'b1;
                            rk_valid   <= 1'b1;
                            state      <= OUT;
                        end
                    end
                    OUT: begin
                        if (rk_ready) begin
                            rk_valid <= 1'b0;
                            if (rk_round == LAST_ROUND) begin
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                rcon_keyid <= '0;
                                state      <= IDLE;
                            end else begin
                                rk_round   <= rk_round + 4'd1;
                                rcon_keyid <= rk_round + 4'd1;
                                state      <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        key_reg  <= {nw0, nw1, nw2, nw3};
                        rk_valid <= 1'b1;
                        state    <= OUT;
                    end
                    // NOTE: the unreachable encoding recovers to IDLE instead
                    // of holding an undefined state.
                    default: begin
                        state    <= IDLE;
                        rk_valid <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_key_expand_ctrl
//   Directed bench for aes_key_expand_ctrl. Provides the S-box and round
//   constant lookup as combinational models and compares the emitted round
//   keys against the FIPS-197 key schedule for 2b7e1516...09cf4f3c.
// -----------------------------------------------------------------------------
module tb_aes_key_expand_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         rk_ready = 1'b0;
    logic [127:0] key_in = '0;
    logic [3:0]   rcon_keyid;
    logic [7:0]   rcon_byte;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_key_expand_ctrl #(.NUM_ROUNDS(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .key_in     (key_in),
        .rcon_keyid (rcon_keyid),
        .rcon_byte  (rcon_byte),
        .sub_in     (sub_in),
        .sub_out    (sub_out),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .rk_data    (rk_data),
        .rk_round   (rk_round),
        .busy       (busy),
        .done       (done)
    );

    // AES S-box, entry 0x00 in the top byte.
    logic [2047:0] sbox_tbl = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return sbox_tbl[2047 - 8 * int'(b) -: 8];
    endfunction

    assign sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                      sbox(sub_in[15:8]),  sbox(sub_in[7:0])};

    always_comb begin
        rcon_byte = 8'h00;
        case (rcon_keyid)
            4'd1:  rcon_byte = 8'h01;
            4'd2:  rcon_byte = 8'h02;
            4'd3:  rcon_byte = 8'h04;
            4'd4:  rcon_byte = 8'h08;
            4'd5:  rcon_byte = 8'h10;
            4'd6:  rcon_byte = 8'h20;
            4'd7:  rcon_byte = 8'h40;
            4'd8:  rcon_byte = 8'h80;
            4'd9:  rcon_byte = 8'h1b;
            4'd10: rcon_byte = 8'h36;
            default: rcon_byte = 8'h00;
        endcase
    end

    // FIPS-197 Appendix A.1 round keys.
    logic [127:0] fips_rk [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic [7:0] exp_rcon [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic [127:0] other_key = 128'h000102030405060708090a0b0c0d0e0f;

    // -------------------------------------------------------------------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            rk_round !== 4'd0 || rcon_keyid !== 4'd0 || rk_data !== '0)
            begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b round=%0d keyid=%0d data=%h, expected all zero",
                     rk_valid, busy, done, rk_round, rcon_keyid, rk_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: valid=%b busy=%b, expected 0 0", rk_valid, busy);
        end
    endtask

    // Full schedule with rk_ready tied high; also checks each CALC cycle's
    // round-constant index and byte.
    task automatic test_fips(input string tag);
        int idx = 0;
        int cyc = 0;
        bit seen_done = 1'b0;
        key_in   = fips_rk[0];
        rk_ready = 1'b1;
        start    = 1'b1;
        while (cyc < 40 && !seen_done) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (rk_valid) begin
                checks++;
                if (idx > 10 || rk_round !== 4'(idx) || rk_data !== fips_rk[idx] || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s key: round=%0d data=%h busy=%b, expected round=%0d data=%h busy=1",
                             tag, rk_round, rk_data, busy, idx, (idx > 10) ? '0 : fips_rk[idx]);
                end
                idx++;
            end else if (busy) begin
                checks++;
                if (idx > 10 || rcon_keyid !== 4'(idx) || rcon_byte !== exp_rcon[idx]) begin
                    errors++;
                    $display("FAIL %s rcon: keyid=%0d byte=%h, expected keyid=%0d byte=%h",
                             tag, rcon_keyid, rcon_byte, idx, (idx > 10) ? 8'h00 : exp_rcon[idx]);
                end
            end
            if (done) begin
                seen_done = 1'b1;
                checks++;
                if (cyc != 22 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_timing: done at cycle %0d busy=%b, expected cycle 22 busy=0",
                             tag, cyc, busy);
                end
            end
        end
        checks++;
        if (!seen_done || idx != 11) begin
            errors++;
            $display("FAIL %s completion: done_seen=%b keys=%0d, expected 1 and 11", tag, seen_done, idx);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || rk_valid !== 1'b0 || rcon_keyid !== 4'd0) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b valid=%b keyid=%0d, expected all 0",
                     tag, done, busy, rk_valid, rcon_keyid);
        end
    endtask

    // Round 3 is held with rk_ready low for 5 cycles.
    task automatic test_backpressure();
        int idx = 0;
        int cyc = 0;
        int stalls = 0;
        bit seen_done = 1'b0;
        key_in   = fips_rk[0];
        rk_ready = 1'b1;
        start    = 1'b1;
        while (cyc < 50 && !seen_done) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (rk_valid) begin
                if (rk_round === 4'd3 && stalls < 5) begin
                    rk_ready = 1'b0;
                    stalls++;
                    checks++;
                    if (rk_data !== fips_rk[3]) begin
                        errors++;
                        $display("FAIL bp_hold: stall %0d data=%h, expected %h", stalls, rk_data, fips_rk[3]);
                    end
                end else begin
                    rk_ready = 1'b1;
                    checks++;
                    if (idx > 10 || rk_round !== 4'(idx) || rk_data !== fips_rk[idx]) begin
                        errors++;
                        $display("FAIL bp_key: round=%0d data=%h, expected round=%0d data=%h",
                                 rk_round, rk_data, idx, (idx > 10) ? '0 : fips_rk[idx]);
                    end
                    idx++;
                end
            end
            if (done) begin
                seen_done = 1'b1;
                checks++;
                if (cyc != 27) begin
                    errors++;
                    $display("FAIL bp_done_timing: done at cycle %0d, expected 27", cyc);
                end
            end
        end
        rk_ready = 1'b1;
        checks++;
        if (!seen_done || idx != 11 || stalls != 5) begin
            errors++;
            $display("FAIL bp_completion: done_seen=%b keys=%0d stalls=%0d, expected 1 11 5",
                     seen_done, idx, stalls);
        end
    endtask

    // A second start with a different key during round 4 must be ignored.
    task automatic test_start_ignored();
        int idx = 0;
        int cyc = 0;
        bit injected = 1'b0;
        bit seen_done = 1'b0;
        key_in   = fips_rk[0];
        rk_ready = 1'b1;
        start    = 1'b1;
        while (cyc < 40 && !seen_done) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (rk_valid) begin
                if (rk_round === 4'd4 && !injected) begin
                    start    = 1'b1;
                    key_in   = other_key;
                    injected = 1'b1;
                end
                checks++;
                if (idx > 10 || rk_round !== 4'(idx) || rk_data !== fips_rk[idx]) begin
                    errors++;
                    $display("FAIL busy_start key: round=%0d data=%h, expected round=%0d data=%h",
                             rk_round, rk_data, idx, (idx > 10) ? '0 : fips_rk[idx]);
                end
                idx++;
            end
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (!seen_done || idx != 11 || cyc != 22) begin
            errors++;
            $display("FAIL busy_start completion: done_seen=%b keys=%0d cycle=%0d, expected 1 11 22",
                     seen_done, idx, cyc);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_start restarted: busy=%b valid=%b, expected 0 0", busy, rk_valid);
        end
    endtask

    // Abort in the CALC cycle of round 6, then abort+start together in IDLE.
    task automatic test_abort();
        int cyc = 0;
        bit hit = 1'b0;
        bit bad = 1'b0;
        key_in   = fips_rk[0];
        rk_ready = 1'b1;
        start    = 1'b1;
        while (cyc < 30 && !hit) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (busy && !rk_valid && rcon_keyid === 4'd6) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort_reach: CALC of round 6 not observed within %0d cycles", cyc);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || rcon_keyid !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: valid=%b busy=%b keyid=%0d done=%b, expected 0 0 0 0",
                     rk_valid, busy, rcon_keyid, done);
        end
        repeat (5) begin
            @(negedge clk);
            if (done !== 1'b0 || rk_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL abort_quiet: activity after abort, expected done/valid/busy all 0");
        end
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_vs_start: busy=%b valid=%b, expected 0 0", busy, rk_valid);
        end
        test_fips("post_abort");
    endtask

    // Asynchronous reset while round 2 is being offered.
    task automatic test_midreset();
        int cyc = 0;
        bit hit = 1'b0;
        key_in   = fips_rk[0];
        rk_ready = 1'b0;
        start    = 1'b1;
        while (cyc < 30 && !hit) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (rk_valid && rk_round === 4'd2) hit = 1'b1;
            else rk_ready = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_reach: round 2 not offered within %0d cycles", cyc);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rk_round !== 4'd0 ||
            rcon_keyid !== 4'd0 || rk_data !== '0 || sub_in !== '0) begin
            errors++;
            $display("FAIL midreset_state: valid=%b busy=%b done=%b round=%0d keyid=%0d data=%h, expected all zero",
                     rk_valid, busy, done, rk_round, rcon_keyid, rk_data);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        rk_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: valid=%b busy=%b done=%b, expected 0 0 0", rk_valid, busy, done);
        end
        test_fips("post_reset");
    endtask

    initial begin
        test_reset();
        test_fips("fips");
        test_backpressure();
        test_start_ignored();
        test_abort();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
